ram_dma: RTL

Word-oriented memory-to-memory DMA initiator that drives the single-port data RAM through its native interface: write enable, byte address, write data, combinational read data. It sits beside the core on the RAM port and performs block copies and block fills without core involvement, so software can move or clear buffers in RAM. It is the initiator end of the RAM access protocol: it issues the addresses and write strobes that the RAM responds to.

---
 rtl/ram_dma.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ram_dma.sv
// ram_dma: word-oriented memory-to-memory DMA initiator on a single-port RAM.
// Performs ascending block copies (read word, write word) or block fills.
// All RAM-port outputs are decoded from registered state only.
module ram_dma #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // mode encoding: 0 = copy, 1 = fill
    localparam logic MODE_FILL = 1'b1;
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q,   src_d;
    logic [ADDR_W-1:0]  dst_q,   dst_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;
    logic               mode_q,  mode_d;
    logic [DATA_W-1:0]  fill_q,  fill_d;
    logic [DATA_W-1:0]  buf_q,   buf_d;

    // State and transfer registers; reset abandons any transfer and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic: latch parameters in IDLE, alternate READ/WRITE for copy,
    // stay in WRITE for fill, finish through a single DONE cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d  = src_addr_i;
                    dst_d  = dst_addr_i;
                    cnt_d  = len_i;
                    mode_d = mode_i;
                    fill_d = fill_data_i;
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (mode_i == MODE_FILL) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d   = mem_rdata_i;
                state_d = WRITE;
            end
            WRITE: begin
                // Addresses wrap modulo 2^ADDR_W; low bits ride along unchanged.
                dst_d = dst_q + WORD_STEP;
                if (mode_q != MODE_FILL) begin
                    src_d = src_q + WORD_STEP;
                end
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else if (mode_q == MODE_FILL) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM-port and status outputs decoded purely from registered state.
    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            READ: begin
                mem_addr_o = src_q;
            end
            WRITE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = dst_q;
                mem_wdata_o = (mode_q == MODE_FILL) ? fill_q : buf_q;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
